// File: rtl/sensor_fsm.sv
// sensor_fsm: direction detector for a two-sensor passage.
// Sensor a is the outer beam and b the inner one. Walking a -> ab -> b -> clear
// is an entry and gives one sumar pulse. The mirror sequence is an exit and
// gives one restar pulse. Aborted or malformed sequences give no pulse.
// Optional synchronizer stages on a/b delay everything by SYNC_STAGES cycles.
module sensor_fsm #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic sumar,
  output logic restar
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_IN1      = 3'd1;
  localparam logic [2:0] S_IN2      = 3'd2;
  localparam logic [2:0] S_IN3      = 3'd3;
  localparam logic [2:0] S_OUT1     = 3'd4;
  localparam logic [2:0] S_OUT2     = 3'd5;
  localparam logic [2:0] S_OUT3     = 3'd6;
  localparam logic [2:0] S_WAIT_CLR = 3'd7;

  // Sensor pair as seen by the FSM, written {a, b}.
  logic [1:0] ab;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ab = {a, b};
    end else begin : g_sync
      logic [1:0] sync_q [SYNC_STAGES];
      logic [1:0] sync_d [SYNC_STAGES];

      // Shift chain: stage 0 captures the raw pins, later stages follow.
      always_comb begin
        sync_d[0] = {a, b};
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchronizer flops, cleared by reset so no stale step survives it.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 2'b00;
          end
        end else begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign ab = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [2:0] state_q, state_d;
  logic       sumar_q, sumar_d;
  logic       restar_q, restar_d;

  // Next-state and pulse decode; a pulse is raised only on the closing
  // 00 step out of IN3/OUT3, so a held 00 in IDLE never retriggers.
  always_comb begin
    state_d  = state_q;
    sumar_d  = 1'b0;
    restar_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (ab)
          2'b10:   state_d = S_IN1;
          2'b01:   state_d = S_OUT1;
          2'b11:   state_d = S_WAIT_CLR;
          default: state_d = S_IDLE;
        endcase
      end
      S_IN1: begin
        case (ab)
          2'b11:   state_d = S_IN2;
          2'b00:   state_d = S_IDLE;
          2'b01:   state_d = S_WAIT_CLR;
          default: state_d = S_IN1;
        endcase
      end
      S_IN2: begin
        case (ab)
          2'b01:   state_d = S_IN3;
          2'b10:   state_d = S_IN1;
          2'b00:   state_d = S_IDLE;
          default: state_d = S_IN2;
        endcase
      end
      S_IN3: begin
        case (ab)
          2'b00: begin
            state_d = S_IDLE;
            sumar_d = 1'b1;
          end
          2'b11:   state_d = S_IN2;
          2'b10:   state_d = S_WAIT_CLR;
          default: state_d = S_IN3;
        endcase
      end
      S_OUT1: begin
        case (ab)
          2'b11:   state_d = S_OUT2;
          2'b00:   state_d = S_IDLE;
          2'b10:   state_d = S_WAIT_CLR;
          default: state_d = S_OUT1;
        endcase
      end
      S_OUT2: begin
        case (ab)
          2'b10:   state_d = S_OUT3;
          2'b01:   state_d = S_OUT1;
          2'b00:   state_d = S_IDLE;
          default: state_d = S_OUT2;
        endcase
      end
      S_OUT3: begin
        case (ab)
          2'b00: begin
            state_d  = S_IDLE;
            restar_d = 1'b1;
          end
          2'b11:   state_d = S_OUT2;
          2'b01:   state_d = S_WAIT_CLR;
          default: state_d = S_OUT3;
        endcase
      end
      default: begin
        if (ab == 2'b00) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and registered pulse outputs; reset abandons any sequence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sumar_q  <= 1'b0;
      restar_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sumar_q  <= sumar_d;
      restar_q <= restar_d;
    end
  end

  assign sumar  = sumar_q;
  assign restar = restar_q;

endmodule

// File: tb/tb_sensor_fsm.sv
// tb_sensor_fsm: directed plus randomized sensor sequences driven into two
// instances (no synchronizer and two synchronizer stages). A sequence-level
// reference model queues the expected pulses; a monitor pops and compares.
module tb_sensor_fsm;

  logic clk = 1'b0;
  logic rst, a, b;
  logic sumar0, restar0, sumar2, restar2;

  sensor_fsm #(.SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sumar(sumar0), .restar(restar0)
  );

  sensor_fsm #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sumar(sumar2), .restar(restar2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int kind;  // 1 = sumar, 2 = restar
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  logic [1:0] hist[int];
  bit         rstv[int];
  int         last_rst;

  // Model state per instance: dir 0 idle, +1 entry, -1 exit, 2 waiting for clear;
  // k is the progress index into the direction's three-step pattern.
  int md[2];
  int mk[2];

  // Step k of the entry (d=+1) or exit (d=-1) pattern.
  function automatic logic [1:0] pat(int d, int k);
    if (k == 1) return 2'b11;
    if (k == 0) return (d == 1) ? 2'b10 : 2'b01;
    return (d == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step(input int i, input logic [1:0] x, output int p);
    p = 0;
    if (md[i] == 0) begin
      if (x == 2'b10) begin md[i] = 1; mk[i] = 0; end
      else if (x == 2'b01) begin md[i] = -1; mk[i] = 0; end
      else if (x == 2'b11) md[i] = 2;
    end else if (md[i] == 2) begin
      if (x == 2'b00) md[i] = 0;
    end else if (x != pat(md[i], mk[i])) begin
      if (x == 2'b00) begin
        if (mk[i] == 2) p = (md[i] == 1) ? 1 : 2;
        md[i] = 0;
      end else if (mk[i] < 2 && x == pat(md[i], mk[i] + 1)) begin
        mk[i] = mk[i] + 1;
      end else if (mk[i] > 0 && x == pat(md[i], mk[i] - 1)) begin
        mk[i] = mk[i] - 1;
      end else begin
        md[i] = 2;
      end
    end
  endtask

  // Drive one step for the next rising edge and predict each instance's pulse.
  task automatic drive(input logic [1:0] x, input logic r);
    int e;
    int p;
    logic [1:0] in;
    exp_t ex;
    @(posedge clk);
    #2;
    a = x[1];
    b = x[0];
    rst = r;
    e = cyc + 1;
    hist[e] = x;
    rstv[e] = r;
    if (!r) begin
      last_rst = e;
      md[0] = 0; md[1] = 0; mk[0] = 0; mk[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        in = (e - 2 * i > last_rst) ? hist[e - 2 * i] : 2'b00;
        model_step(i, in, p);
        if (p != 0) begin
          ex.cyc = e;
          ex.kind = p;
          if (i == 0) q0.push_back(ex);
          else q2.push_back(ex);
        end
      end
    end
  endtask

  // Play n two-bit steps packed MSB-first in s, each held for hold cycles.
  task automatic run(input logic [15:0] s, input int n, input int hold);
    for (int j = 0; j < n; j++) begin
      for (int h = 0; h < hold; h++) drive(s[2*(n-1-j) +: 2], 1'b1);
    end
  endtask

  task automatic check(input int i, input logic s, input logic r);
    exp_t ex;
    string nm;
    int got;
    nm = (i == 0) ? "sync0" : "sync2";
    got = s ? 1 : 2;
    if (s && r) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s both_pulses cycle %0d: sumar=1 restar=1, required at most one", nm, cyc);
    end else if (s || r) begin
      n_cmp++;
      if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) ex = q0.pop_front();
      else if (i == 1 && q2.size() > 0 && q2[0].cyc == cyc) ex = q2.pop_front();
      else ex.kind = 0;
      if (ex.kind != got) begin
        n_bad++;
        $display("FAIL %s pulse cycle %0d: got kind %0d, required kind %0d (0=none 1=sumar 2=restar)",
                 nm, cyc, got, ex.kind);
      end
    end
    if (i == 0) begin
      while (q0.size() > 0 && q0[0].cyc <= cyc) begin
        ex = q0.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s missed_pulse cycle %0d: got none, required kind %0d", nm, ex.cyc, ex.kind);
      end
    end else begin
      while (q2.size() > 0 && q2[0].cyc <= cyc) begin
        ex = q2.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s missed_pulse cycle %0d: got none, required kind %0d", nm, ex.cyc, ex.kind);
      end
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rstv.exists(cyc) && !rstv[cyc]) begin
        n_cmp++;
        if ({sumar0, restar0, sumar2, restar2} !== 4'b0000) begin
          n_bad++;
          $display("FAIL reset_outputs cycle %0d: got %b, required 0000", cyc,
                   {sumar0, restar0, sumar2, restar2});
        end
      end
      check(0, sumar0, restar0);
      check(1, sumar2, restar2);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int d;
    int k;
    rst = 1'b0;
    a = 1'b0;
    b = 1'b0;
    last_rst = 1;
    hist[1] = 2'b00;
    rstv[1] = 1'b0;
    md[0] = 0; md[1] = 0; mk[0] = 0; mk[1] = 0;

    drive(2'b00, 1'b0);
    run(16'b10_11_01_00, 4, 1);               // entry
    run(16'b00_00, 2, 1);
    run(16'b01_11_10_00, 4, 1);               // exit
    run(16'b00_11_00, 3, 1);                  // malformed
    run(16'b10_11_01_00, 4, 1);               // entry still works
    run(16'b10_00, 2, 1);                     // abort
    run(16'b10_11_01_11_01_00, 6, 1);         // entry with backtrack
    run(16'b01_11_10_11_10_00, 6, 1);         // exit with backtrack
    run(16'b10_11_01, 3, 1);                  // reset mid-sequence
    drive(2'b01, 1'b0);
    run(16'b00_00_00_00, 4, 1);
    run(16'b10_11_01_00, 4, 3);               // held steps
    run(16'b10_11_01_00_01_11_10_00, 8, 1);   // back-to-back entry then exit
    run(16'b10_01_00, 3, 1);                  // skipped step
    run(16'b00_00_00, 3, 1);

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drive(2'($urandom_range(0, 3)), 1'b0);
      end else if (r <= 2) begin
        d = $urandom_range(1, 3);
        k = $urandom_range(0, 3);
        for (int h = 0; h < d; h++) drive(2'(k), 1'b1);
      end else begin
        d = ($urandom_range(0, 1) == 1) ? 1 : -1;
        k = 0;
        for (int s = 0; s < 8; s++) begin
          r = $urandom_range(1, 3);
          for (int h = 0; h < r; h++) drive(pat(d, k), 1'b1);
          if (k > 0 && $urandom_range(0, 3) == 0) k--;
          else k++;
          if (k == 3) break;
        end
        drive(2'b00, 1'b1);
      end
    end

    run(16'b00_00_00_00_00_00, 6, 1);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q0.size() != 0 || q2.size() != 0) begin
      n_bad++;
      $display("FAIL pending_pulses: got %0d/%0d still queued, required 0/0", q0.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
